// File: rtl/xif_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : xif_mem_responder
// Brief    : XIF memory request/result responder bridging coprocessor requests
//            onto an OBI data port, returning in-order results.
// Revision : 1.0 - initial release
// ============================================================================
module xif_mem_responder #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                x_mem_valid_i,
    output logic                x_mem_ready_o,
    input  logic [ID_WIDTH-1:0] x_mem_req_id_i,
    input  logic [31:0]         x_mem_req_addr_i,
    input  logic                x_mem_req_we_i,
    input  logic [1:0]          x_mem_req_size_i,
    input  logic [31:0]         x_mem_req_wdata_i,
    input  logic                x_mem_req_last_i,

    output logic                x_mem_result_valid_o,
    output logic [ID_WIDTH-1:0] x_mem_result_id_o,
    output logic [31:0]         x_mem_result_rdata_o,
    output logic                x_mem_result_err_o,

    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_wdata_o,
    input  logic                data_rvalid_i,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i,

    output logic                spurious_rvalid_o
);

    localparam int unsigned c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt  = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(MAX_OUTSTANDING - 1);

    // Metadata FIFO storage
    logic [ID_WIDTH-1:0] r_id_q   [MAX_OUTSTANDING];
    logic                r_we_q   [MAX_OUTSTANDING];
    logic [1:0]          r_size_q [MAX_OUTSTANDING];
    logic [1:0]          r_off_q  [MAX_OUTSTANDING];
    logic                r_lerr_q [MAX_OUTSTANDING];

    logic [c_ptr_w-1:0]  r_wptr, r_rptr;
    logic [c_cnt_w-1:0]  r_count, r_bus_cnt;

    logic                r_hold_valid;
    logic [31:0]         r_hold_rdata;
    logic                r_hold_err;

    logic                r_res_valid;
    logic [ID_WIDTH-1:0] r_res_id;
    logic [31:0]         r_res_rdata;
    logic                r_res_err;
    logic                r_spurious;

    logic                w_misaligned, w_room, w_push, w_pop, w_bus_issue;
    logic                w_rsp, w_nonempty, w_use_hold, w_hold_capture;
    logic                w_head_lerr, w_head_we;
    logic [1:0]          w_head_size, w_head_off;
    logic [ID_WIDTH-1:0] w_head_id;
    logic [31:0]         w_src_rdata, w_shifted, w_load, w_res_rdata;
    logic                w_src_err, w_res_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic                w_unused_last;

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    assign w_unused_last = x_mem_req_last_i;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_misaligned = ((x_mem_req_size_i == 2'd1) & x_mem_req_addr_i[0])
                        | ((x_mem_req_size_i == 2'd2) & (x_mem_req_addr_i[1:0] != 2'b00))
                        |  (x_mem_req_size_i == 2'd3);
    assign w_room        = r_count < c_max_cnt;
    assign data_req_o    = x_mem_valid_i & ~w_misaligned & w_room;
    assign x_mem_ready_o = w_room & (w_misaligned | data_gnt_i);
    assign w_push        = x_mem_valid_i & x_mem_ready_o;
    assign w_bus_issue   = data_req_o & data_gnt_i;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = x_mem_req_wdata_i;
        case (x_mem_req_size_i)
            2'd0: begin
                w_be    = 4'b0001 << x_mem_req_addr_i[1:0];
                w_wdata = {4{x_mem_req_wdata_i[7:0]}};
            end
            2'd1: begin
                w_be    = 4'b0011 << x_mem_req_addr_i[1:0];
                w_wdata = {2{x_mem_req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign data_addr_o  = {x_mem_req_addr_i[31:2], 2'b00};
    assign data_we_o    = x_mem_req_we_i;
    assign data_be_o    = w_be;
    assign data_wdata_o = w_wdata;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    assign w_nonempty  = r_count != '0;
    assign w_head_id   = r_id_q[r_rptr];
    assign w_head_we   = r_we_q[r_rptr];
    assign w_head_size = r_size_q[r_rptr];
    assign w_head_off  = r_off_q[r_rptr];
    assign w_head_lerr = w_nonempty & r_lerr_q[r_rptr];

    // rvalid with nothing on the bus is dropped and only flagged
    assign w_rsp          = data_rvalid_i & (r_bus_cnt != '0);
    assign w_use_hold     = r_hold_valid & ~w_head_lerr;
    assign w_pop          = w_nonempty & (w_head_lerr | r_hold_valid | w_rsp);
    // A response that cannot be consumed right now waits in the hold register
    assign w_hold_capture = w_rsp & (w_head_lerr | r_hold_valid);

    always_comb begin
        w_src_rdata = w_use_hold ? r_hold_rdata : data_rdata_i;
        w_src_err   = w_use_hold ? r_hold_err   : data_err_i;
        w_shifted   = w_src_rdata >> {w_head_off, 3'b000};
        case (w_head_size)
            2'd0:    w_load = {24'b0, w_shifted[7:0]};
            2'd1:    w_load = {16'b0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
        w_res_rdata = (w_head_lerr | w_head_we) ? 32'b0 : w_load;
        w_res_err   = w_head_lerr | w_src_err;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id_q[r_wptr]   <= x_mem_req_id_i;
            r_we_q[r_wptr]   <= x_mem_req_we_i;
            r_size_q[r_wptr] <= x_mem_req_size_i;
            r_off_q[r_wptr]  <= x_mem_req_addr_i[1:0];
            r_lerr_q[r_wptr] <= w_misaligned;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_bus_cnt    <= '0;
            r_hold_valid <= 1'b0;
            r_hold_rdata <= '0;
            r_hold_err   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_id     <= '0;
            r_res_rdata  <= '0;
            r_res_err    <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= f_ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= f_ptr_inc(r_rptr);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase

            case ({w_bus_issue, w_rsp})
                2'b10:   r_bus_cnt <= r_bus_cnt + 1'b1;
                2'b01:   r_bus_cnt <= r_bus_cnt - 1'b1;
                default: ;
            endcase

            if (w_hold_capture) begin
                r_hold_valid <= 1'b1;
                r_hold_rdata <= data_rdata_i;
                r_hold_err   <= data_err_i;
            end else if (w_use_hold && w_pop) begin
                r_hold_valid <= 1'b0;
            end

            r_res_valid <= w_pop;
            if (w_pop) begin
                r_res_id    <= w_head_id;
                r_res_rdata <= w_res_rdata;
                r_res_err   <= w_res_err;
            end

            if (data_rvalid_i && (r_bus_cnt == '0)) r_spurious <= 1'b1;
        end
    end

    assign x_mem_result_valid_o = r_res_valid;
    assign x_mem_result_id_o    = r_res_id;
    assign x_mem_result_rdata_o = r_res_rdata;
    assign x_mem_result_err_o   = r_res_err;
    assign spurious_rvalid_o    = r_spurious;

endmodule
`default_nettype wire
